// File: rtl/coin_pkg.sv
// Coin codes and values shared by the coin acceptor and the vending FSM.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_e;

  localparam logic [15:0] COIN_5_VALUE  = 16'd5;
  localparam logic [15:0] COIN_10_VALUE = 16'd10;

  function automatic logic [15:0] coin_value(coin_e c);
    case (c)
      COIN_5:  return COIN_5_VALUE;
      COIN_10: return COIN_10_VALUE;
      default: return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor/control/status bundle of the coin acceptor.
// audit_total exists only when COIN_AUDIT_EN is defined.
interface coin_acceptor_if;
  import coin_pkg::*;

  logic  sensor_5;
  logic  sensor_10;
  logic  accept_hold;
  coin_e coin;
  logic  fifo_full;
  logic  overflow;
  logic  jam;
`ifdef COIN_AUDIT_EN
  logic [15:0] audit_total;

  modport master (
    output sensor_5, sensor_10, accept_hold,
    input  coin, fifo_full, overflow, jam, audit_total
  );
  modport slave (
    input  sensor_5, sensor_10, accept_hold,
    output coin, fifo_full, overflow, jam, audit_total
  );
`else
  modport master (
    output sensor_5, sensor_10, accept_hold,
    input  coin, fifo_full, overflow, jam
  );
  modport slave (
    input  sensor_5, sensor_10, accept_hold,
    output coin, fifo_full, overflow, jam
  );
`endif

endinterface

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus saturating stability counter for one coin sensor;
// accept pulses once per stable-high period.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // accept is registered alongside the count reaching CNT_MAX, so it fires
  // exactly on that cycle and never again while cnt sits saturated.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync   <= 2'b00;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      sync   <= {sync[0], raw};
      accept <= sync[1] && (cnt == CNT_FIRE);
      if (!sync[1])
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the $5/$10 sensors, queues coin codes and releases them
// one per clock. Define COIN_AUDIT_EN to add the audit_total running value.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input logic            clk,
  input logic            reset_n,
  coin_acceptor_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  logic accept_5;
  logic accept_10;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_5 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bus.sensor_5),
    .accept  (accept_5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_10 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bus.sensor_10),
    .accept  (accept_10)
  );

  coin_e          mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  coin_e          coin_q;
  logic           overflow_q;
  logic           full;
  logic           push_req;
  logic           do_push;
  logic           pop;
  coin_e          push_code;

  always_comb begin
    push_req  = accept_5 ^ accept_10;
    push_code = accept_5 ? COIN_5 : COIN_10;
    full      = (count == COUNT_FULL);
    pop       = (count != '0) && !bus.accept_hold;
    // A pop in the same cycle frees the slot the push needs.
    do_push   = push_req && (!full || pop);
    count_next = count;
    if (do_push && !pop)
      count_next = count + 1'b1;
    else if (!do_push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      coin_q     <= COIN_NONE;
      overflow_q <= 1'b0;
    end else begin
      count  <= count_next;
      coin_q <= pop ? mem[rd_ptr] : COIN_NONE;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop)
        overflow_q <= 1'b1;
    end
  end

  assign bus.coin      = coin_q;
  assign bus.fifo_full = full;
  assign bus.overflow  = overflow_q;
  assign bus.jam       = accept_5 & accept_10;

`ifdef COIN_AUDIT_EN
  logic [15:0] audit_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      audit_q <= 16'd0;
    else if (pop)
      audit_q <= audit_q + coin_value(mem[rd_ptr]);
  end

  assign bus.audit_total = audit_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed table, corner-case sequences and random
// sensor activity checked against a queue-based reference model.
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int D     = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;

  coin_acceptor_if bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;

  // Reference model: run length of high sensor samples, visible accept pulses,
  // and a plain queue of pending codes.
  int rl1 [2];
  int rl2 [2];
  bit acc_v [2];
  int q [$];
  bit m_ovf;
  int m_coin;
  int m_audit;

  typedef struct {
    bit       rst;
    bit       s5;
    bit       s10;
    bit       hold;
    bit [1:0] coin;
    bit       full;
    bit       ovf;
    bit       jam;
  } vec_t;

  vec_t tbl [19];

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n - 1);
    end
  endfunction

  task automatic model_edge(input bit rst, input bit s5, input bit s10, input bit h);
    bit raw [2];
    bit acc_new [2];
    int popped;
    raw[0] = s5;
    raw[1] = s10;
    if (rst) begin
      q.delete();
      m_coin  = 0;
      m_ovf   = 0;
      m_audit = 0;
      for (int i = 0; i < 2; i++) begin
        rl1[i] = 0; rl2[i] = 0; acc_v[i] = 0;
      end
      return;
    end
    // A coin is accepted when the synchronised level (raw delayed two samples)
    // has been high for exactly D consecutive samples.
    for (int i = 0; i < 2; i++) begin
      acc_new[i] = (rl2[i] == D);
      rl2[i] = rl1[i];
      rl1[i] = raw[i] ? ((rl1[i] < D + 1) ? rl1[i] + 1 : D + 1) : 0;
    end
    popped = 0;
    if (q.size() > 0 && !h) popped = q.pop_front();
    m_coin  = popped;
    m_audit = (m_audit + (popped == 1 ? 5 : (popped == 2 ? 10 : 0))) % 65536;
    if (acc_v[0] ^ acc_v[1]) begin
      if (q.size() < DEPTH) q.push_back(acc_v[0] ? 1 : 2);
      else m_ovf = 1;
    end
    acc_v = acc_new;
  endtask

  task automatic drive(input bit rst, input bit s5, input bit s10, input bit h);
    reset_n         = !rst;
    bus.sensor_5    = s5;
    bus.sensor_10   = s10;
    bus.accept_hold = h;
    @(posedge clk);
    model_edge(rst, s5, s10, h);
    edge_n++;
    #1;
  endtask

  task automatic check_model();
    check("coin", 16'(bus.coin), 16'(m_coin));
    check("fifo_full", 16'(bus.fifo_full), 16'(q.size() == DEPTH));
    check("overflow", 16'(bus.overflow), 16'(m_ovf));
    check("jam", 16'(bus.jam), 16'(acc_v[0] & acc_v[1]));
`ifdef COIN_AUDIT_EN
    check("audit_total", bus.audit_total, 16'(m_audit));
`endif
  endtask

  task automatic step(input bit rst, input bit s5, input bit s10, input bit h);
    drive(rst, s5, s10, h);
    check_model();
  endtask

  task automatic insert(input bit s5, input bit s10, input bit h);
    for (int i = 0; i < 10; i++) step(0, s5, s10, h);
    for (int i = 0; i < 3; i++) step(0, 0, 0, h);
  endtask

  initial begin
    int stable, first_edge, n5, njam, ncode, nout;
    int got [4];
    int t5, t10, th;
    bit l5, l10, lh, rr;

    // Directed table: reset, then one clean $5 insertion.
    tbl[0] = '{rst: 1, s5: 0, s10: 0, hold: 0, coin: 2'b00, full: 0, ovf: 0, jam: 0};
    for (int k = 0; k < 18; k++)
      tbl[k+1] = '{rst: 0, s5: (k < 14), s10: 0, hold: 0,
                   coin: (k == D + 3) ? 2'b01 : 2'b00, full: 0, ovf: 0, jam: 0};

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].s5, tbl[i].s10, tbl[i].hold);
      check("tbl_coin", 16'(bus.coin), 16'(tbl[i].coin));
      check("tbl_full", 16'(bus.fifo_full), 16'(tbl[i].full));
      check("tbl_overflow", 16'(bus.overflow), 16'(tbl[i].ovf));
      check("tbl_jam", 16'(bus.jam), 16'(tbl[i].jam));
    end

    // Bouncy $5: three toggles then stable high.
    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    stable = edge_n;
    first_edge = -1;
    n5 = 0;
    for (int i = 0; i < 26; i++) begin
      step(0, (i < 20), 0, 0);
      if (bus.coin == COIN_5) begin
        n5++;
        if (first_edge < 0) first_edge = edge_n - 1;
      end
    end
    check("bounce_count", 16'(n5), 16'd1);
    check("bounce_latency", 16'(first_edge - stable), 16'(D + 3));

    // $5 then $10 queued under hold, released back-to-back.
    insert(1, 0, 1);
    insert(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      got[i] = int'(bus.coin);
    end
    check("release_0", 16'(got[0]), 16'(COIN_5));
    check("release_1", 16'(got[1]), 16'(COIN_10));
    check("release_2", 16'(got[2]), 16'(COIN_NONE));
    check("release_3", 16'(got[3]), 16'(COIN_NONE));

    // Both sensors together: one jam pulse, no code.
    njam = 0;
    ncode = 0;
    for (int i = 0; i < 18; i++) begin
      step(0, (i < 12), (i < 12), 0);
      if (bus.jam) njam++;
      if (bus.coin != COIN_NONE) ncode++;
    end
    check("jam_pulses", 16'(njam), 16'd1);
    check("jam_codes", 16'(ncode), 16'd0);

    // Five coins into a four-entry queue under hold.
    for (int i = 0; i < 5; i++) insert(i[0], !i[0], 1);
    check("ovf_full", 16'(bus.fifo_full), 16'd1);
    check("ovf_sticky", 16'(bus.overflow), 16'd1);
    nout = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      if (bus.coin != COIN_NONE) nout++;
    end
    check("ovf_released", 16'(nout), 16'(DEPTH));
    check("ovf_after_drain", 16'(bus.overflow), 16'd1);

    // Reset with three coins queued.
    for (int i = 0; i < 3; i++) insert(1, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check("rst_coin", 16'(bus.coin), 16'(COIN_NONE));
      check("rst_full", 16'(bus.fifo_full), 16'd0);
      check("rst_overflow", 16'(bus.overflow), 16'd0);
    end

`ifdef COIN_AUDIT_EN
    insert(0, 1, 1);
    insert(1, 0, 1);
    insert(0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("audit_25", bus.audit_total, 16'd25);
`endif

    // Random sensor activity with held levels of random length.
    t5 = 0; t10 = 0; th = 0;
    l5 = 0; l10 = 0; lh = 0;
    for (int i = 0; i < 1500; i++) begin
      if (t5 == 0) begin l5 = 1'($urandom_range(0, 1)); t5 = $urandom_range(1, 14); end
      if (t10 == 0) begin l10 = 1'($urandom_range(0, 1)); t10 = $urandom_range(1, 14); end
      if (th == 0) begin lh = 1'($urandom_range(0, 1)); th = $urandom_range(1, 20); end
      t5--; t10--; th--;
      rr = ($urandom_range(0, 299) == 0);
      step(rr, l5, l10, lh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
